// File: rtl/vga_scan_driver.sv
// VGA scan-timing generator: pixel divider, raster counters, registered and blanked
// RGB with syncs, per-frame strobe and the sprite animation frame index.
module vga_scan_driver #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter bit          SYNC_ACTIVE = 1'b0,
  parameter int unsigned ANIM_DIV    = 8,
  parameter int unsigned ANIM_LAST   = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [11:0]        pix_color,
  output logic signed [10:0] x_VGA,
  output logic signed [10:0] y_VGA,
  output logic [3:0]         vga_r,
  output logic [3:0]         vga_g,
  output logic [3:0]         vga_b,
  output logic               hsync,
  output logic               vsync,
  output logic               pix_tick,
  output logic               frame_start,
  output logic [2:0]         anim_frame
);

  localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned CNT_W     = 11;
  localparam int unsigned DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned ANIM_W    = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int unsigned HS_FIRST  = H_ACTIVE + H_FP;
  localparam int unsigned HS_LAST   = H_ACTIVE + H_FP + H_SYNC - 1;
  localparam int unsigned VS_FIRST  = V_ACTIVE + V_FP;
  localparam int unsigned VS_LAST   = V_ACTIVE + V_FP + V_SYNC - 1;
  localparam logic        SYNC_ON   = SYNC_ACTIVE;
  localparam logic        SYNC_OFF  = ~SYNC_ACTIVE;

  logic [DIV_W-1:0]  div_q;
  logic [CNT_W-1:0]  h_q;
  logic [CNT_W-1:0]  v_q;
  logic [ANIM_W-1:0] frm_q;

  logic tick_c;
  logic h_last_c;
  logic v_last_c;
  logic wrap_c;
  logic active_c;
  logic hs_on_c;
  logic vs_on_c;

  // Decode of the current (pre-increment) scan position.
  assign tick_c   = (div_q == DIV_W'(CLK_DIV - 1));
  assign h_last_c = (h_q == CNT_W'(H_TOTAL - 1));
  assign v_last_c = (v_q == CNT_W'(V_TOTAL - 1));
  assign wrap_c   = tick_c && h_last_c && v_last_c;
  assign active_c = (h_q < CNT_W'(H_ACTIVE)) && (v_q < CNT_W'(V_ACTIVE));
  assign hs_on_c  = (h_q >= CNT_W'(HS_FIRST)) && (h_q <= CNT_W'(HS_LAST));
  assign vs_on_c  = (v_q >= CNT_W'(VS_FIRST)) && (v_q <= CNT_W'(VS_LAST));

  // Counters stay in range, so the zero-extended signed view is never negative.
  assign x_VGA = $signed(h_q);
  assign y_VGA = $signed(v_q);

  // Pixel-rate divider; pix_tick marks the clk in which the new position appears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= '0;
      pix_tick <= 1'b0;
    end else begin
      pix_tick <= tick_c;
      div_q    <= tick_c ? '0 : div_q + DIV_W'(1);
    end
  end

  // Raster counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q <= '0;
      v_q <= '0;
    end else if (tick_c) begin
      if (h_last_c) begin
        h_q <= '0;
        v_q <= v_last_c ? '0 : v_q + CNT_W'(1);
      end else begin
        h_q <= h_q + CNT_W'(1);
      end
    end
  end

  // Output stage lags the counters by one pixel, so RGB and syncs stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_r <= '0;
      vga_g <= '0;
      vga_b <= '0;
      hsync <= SYNC_OFF;
      vsync <= SYNC_OFF;
    end else if (tick_c) begin
      {vga_r, vga_g, vga_b} <= active_c ? pix_color : 12'h000;
      hsync <= hs_on_c ? SYNC_ON : SYNC_OFF;
      vsync <= vs_on_c ? SYNC_ON : SYNC_OFF;
    end
  end

  // Frame strobe and animation index; anim_frame only moves with frame_start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_start <= 1'b0;
      frm_q       <= '0;
      anim_frame  <= '0;
    end else begin
      frame_start <= wrap_c;
      if (wrap_c) begin
        if (frm_q == ANIM_W'(ANIM_DIV - 1)) begin
          frm_q      <= '0;
          anim_frame <= (anim_frame == 3'(ANIM_LAST)) ? 3'd0 : anim_frame + 3'd1;
        end else begin
          frm_q <= frm_q + ANIM_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_scan_driver.sv
// Bench for vga_scan_driver on a shrunken raster (15x10 pixels, 4 clks/pixel)
// so whole frames and animation wraps fit in a short run.
module tb_vga_scan_driver;

  localparam int unsigned CLK_DIV   = 4;
  localparam int unsigned H_ACTIVE  = 8;
  localparam int unsigned H_FP      = 2;
  localparam int unsigned H_SYNC    = 3;
  localparam int unsigned H_BP      = 2;
  localparam int unsigned V_ACTIVE  = 5;
  localparam int unsigned V_FP      = 1;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BP      = 2;
  localparam int unsigned ANIM_DIV  = 4;
  localparam int unsigned ANIM_LAST = 7;
  localparam int          HT        = 15;
  localparam int          VT        = 10;
  localparam int          FT        = 150;
  localparam int          N_FRAMES  = 36;
  localparam int          N2        = N_FRAMES * FT * 4 + 200;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [11:0]        pix_color = 12'h000;
  logic signed [10:0] x_VGA;
  logic signed [10:0] y_VGA;
  logic [3:0]         vga_r;
  logic [3:0]         vga_g;
  logic [3:0]         vga_b;
  logic               hsync;
  logic               vsync;
  logic               pix_tick;
  logic               frame_start;
  logic [2:0]         anim_frame;

  vga_scan_driver #(
    .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_ACTIVE(1'b0), .ANIM_DIV(ANIM_DIV), .ANIM_LAST(ANIM_LAST)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_color(pix_color),
    .x_VGA(x_VGA), .y_VGA(y_VGA), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .hsync(hsync), .vsync(vsync), .pix_tick(pix_tick), .frame_start(frame_start),
    .anim_frame(anim_frame)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          n;
    int          x;
    int          y;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        tk;
    logic        fs;
    logic [2:0]  an;
  } vec_t;

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
  } pix_t;

  vec_t        vt[21];
  pix_t        sb[$];
  pix_t        cur;
  int          vec_cnt = 0;
  int          err_cnt = 0;
  int          cur_n;
  int          p;
  int          fs_cnt;
  int          last_fs;
  logic        tk;
  logic        fs;
  logic [2:0]  an;
  logic [11:0] col;
  logic [40:0] dut_out;

  // Packed view: {x, y, rgb, hsync, vsync, pix_tick, frame_start, anim_frame}.
  assign dut_out = {x_VGA, y_VGA, vga_r, vga_g, vga_b, hsync, vsync, pix_tick, frame_start, anim_frame};

  function automatic logic [40:0] pack_exp(int x, int y, logic [11:0] rgb, logic hs, logic vs,
                                           logic tkv, logic fsv, logic [2:0] anv);
    return {11'(x), 11'(y), rgb, hs, vs, tkv, fsv, anv};
  endfunction

  // Expected registered output for a presented pixel index with its chooser colour.
  function automatic pix_t pix_exp(int pi, logic [11:0] c);
    pix_t r;
    int   x;
    int   y;
    x = pi % HT;
    y = (pi / HT) % VT;
    r.rgb = (x < 8 && y < 5) ? c : 12'h000;
    r.hs  = (x >= 10 && x <= 12) ? 1'b0 : 1'b1;
    r.vs  = (y >= 6 && y <= 7) ? 1'b0 : 1'b1;
    return r;
  endfunction

  task automatic check(input string name, input int n, input logic [40:0] exp);
    vec_cnt++;
    if (dut_out !== exp) begin
      err_cnt++;
      $display("FAIL %s n=%0d got x=%0d y=%0d rgb=%h hs=%b vs=%b tick=%b fs=%b anim=%0d, expected {x,y,rgb,hs,vs,tick,fs,anim}=%0d,%0d,%h,%b,%b,%b,%b,%0d",
               name, n, x_VGA, y_VGA, {vga_r, vga_g, vga_b}, hsync, vsync, pix_tick, frame_start,
               anim_frame, exp[40:30], exp[29:19], exp[18:7], exp[6], exp[5], exp[4], exp[3], exp[2:0]);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    vec_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    // n = clks after release; samples are 1 time unit after the edge.
    vt[0]  = '{0,   0, 0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0};
    vt[1]  = '{3,   0, 0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0};
    vt[2]  = '{4,   1, 0, 12'hFFF, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0};
    vt[3]  = '{5,   1, 0, 12'hFFF, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0};
    vt[4]  = '{32,  8, 0, 12'hFFF, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0};
    vt[5]  = '{36,  9, 0, 12'h000, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0};
    vt[6]  = '{40, 10, 0, 12'h000, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0};
    vt[7]  = '{44, 11, 0, 12'h000, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0};
    vt[8]  = '{47, 11, 0, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
    vt[9]  = '{52, 13, 0, 12'h000, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0};
    vt[10] = '{56, 14, 0, 12'h000, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0};
    vt[11] = '{60,  0, 1, 12'h000, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0};
    vt[12] = '{64,  1, 1, 12'hFFF, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0};
    vt[13] = '{304, 1, 5, 12'h000, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0};
    vt[14] = '{360, 0, 6, 12'h000, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0};
    vt[15] = '{364, 1, 6, 12'h000, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0};
    vt[16] = '{480, 0, 8, 12'h000, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0};
    vt[17] = '{484, 1, 8, 12'h000, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0};
    vt[18] = '{600, 0, 0, 12'h000, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0};
    vt[19] = '{601, 0, 0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0};
    vt[20] = '{604, 1, 0, 12'hFFF, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0};

    // Table phase: constant white from the chooser, boundary positions.
    pix_color = 12'hFFF;
    do_reset();
    cur_n = 0;
    for (int i = 0; i < 21; i++) begin
      while (cur_n < vt[i].n) begin
        @(posedge clk);
        #1;
        cur_n++;
      end
      check($sformatf("table[%0d]", i), vt[i].n,
            pack_exp(vt[i].x, vt[i].y, vt[i].rgb, vt[i].hs, vt[i].vs, vt[i].tk, vt[i].fs, vt[i].an));
    end

    // Free-run phase: random colour per pixel, expected outputs queued per presented pixel.
    do_reset();
    sb.delete();
    cur = '{12'h000, 1'b1, 1'b1};
    col = 12'($urandom);
    pix_color = col;
    sb.push_back(pix_exp(0, col));
    fs_cnt = 0;
    last_fs = 0;
    for (int n = 1; n <= N2; n++) begin
      @(posedge clk);
      #1;
      tk = (n % 4 == 0);
      p = n / 4;
      if (tk) begin
        cur = sb.pop_front();
        col = 12'($urandom);
        pix_color = col;
        sb.push_back(pix_exp(p, col));
      end
      fs = tk && (p % FT == 0);
      an = 3'((p / FT / 4) % 8);
      if (tk || (n % 4 == 2))
        check("scan", n, pack_exp(p % HT, (p / HT) % VT, cur.rgb, cur.hs, cur.vs, tk, fs, an));
      if (frame_start) begin
        fs_cnt++;
        check_int("frame_period", n - last_fs, 600);
        last_fs = n;
        if (fs_cnt == 4)  check_int("anim_first_step", int'(anim_frame), 1);
        if (fs_cnt == 28) check_int("anim_reach_last", int'(anim_frame), 7);
        if (fs_cnt == 32) check_int("anim_wrap", int'(anim_frame), 0);
      end
    end
    check_int("frame_count", fs_cnt, N_FRAMES);

    // Mid-frame reset at (5,3) with anim_frame=1: asynchronous return to reset values.
    rst_n = 1'b0;
    #1;
    check("async_reset", 0, pack_exp(0, 0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0));
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", 0, pack_exp(0, 0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0));
    @(negedge clk);
    rst_n = 1'b1;
    pix_color = 12'hA5C;
    #1;
    check("reset_release", 0, pack_exp(0, 0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0));
    repeat (3) @(posedge clk);
    #1;
    check("restart_pre_tick", 3, pack_exp(0, 0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0));
    @(posedge clk);
    #1;
    check("restart_first_tick", 4, pack_exp(1, 0, 12'hA5C, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
